// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: FSM encoding,
// default command bytes and memory depth.
package program_loader_pkg;

  localparam int DEFAULT_MEM_DEPTH = 32;

  localparam logic [7:0] CMD_LOAD_BYTE = 8'h4C;
  localparam logic [7:0] CMD_RUN_BYTE  = 8'h52;
  localparam logic [7:0] CMD_HALT_BYTE = 8'h48;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GET_LEN  = 3'd1;
  localparam logic [2:0] ST_GET_BYTE = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // Word address width, kept at least one bit for a single-word memory.
  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Loadable down-counter that flags when TIMEOUT_CYC cycles pass without a reload.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic expired_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYC);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (count_q != '0) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The last counted cycle is the one where the count sits at one.
  assign expired_o = !load_i && (count_q == TW'(1));

endmodule

// File: rtl/program_loader.sv
// Debug-serial program loader: receives a length-prefixed word stream,
// writes it into instruction memory and controls the CPU hold line.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int         MEM_DEPTH   = DEFAULT_MEM_DEPTH,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] CMD_LOAD    = CMD_LOAD_BYTE,
  parameter logic [7:0] CMD_RUN     = CMD_RUN_BYTE,
  parameter logic [7:0] CMD_HALT    = CMD_HALT_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] pc_addr,
  output logic [31:0] imem_addr,
  output logic        wr_instruction,
  output logic [31:0] data_instruction,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic        busy
);

  localparam int AW = addrWidth(MEM_DEPTH);
  localparam int CW = $clog2(MEM_DEPTH + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wordCount_q, wordCount_d;
  logic [AW-1:0] wordAddr_q, wordAddr_d;
  logic [1:0]    byteIdx_q, byteIdx_d;
  logic [31:0]   assembly_q, assembly_d;
  logic [31:0]   dataInstr_q, dataInstr_d;
  logic [7:0]    hold_q, hold_d;
  logic          holdValid_q, holdValid_d;
  logic          cpuHold_q, cpuHold_d;
  logic          loadErr_q, loadErr_d;

  logic       effValid;
  logic [7:0] effData;
  logic       lenOk;
  logic       lastWord;
  logic       waiting;
  logic       tmoLoad;
  logic       tmoExpired;

  // A byte parked during WRITE/DONE takes precedence over the live receiver.
  assign effValid = rx_valid | holdValid_q;
  assign effData  = holdValid_q ? hold_q : rx_data;
  assign lenOk    = (effData != 8'd0) && (int'({24'd0, effData}) <= MEM_DEPTH);
  assign lastWord = (CW'(wordAddr_q) + CW'(1)) == wordCount_q;

  assign waiting = (state_q == ST_GET_LEN) || (state_q == ST_GET_BYTE);
  assign tmoLoad = !waiting || effValid;

  loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load_i   (tmoLoad),
    .expired_o(tmoExpired)
  );

  always_comb begin
    state_d     = state_q;
    wordCount_d = wordCount_q;
    wordAddr_d  = wordAddr_q;
    byteIdx_d   = byteIdx_q;
    assembly_d  = assembly_q;
    dataInstr_d = dataInstr_q;
    hold_d      = hold_q;
    holdValid_d = 1'b0;
    cpuHold_d   = cpuHold_q;
    loadErr_d   = loadErr_q;

    case (state_q)
      ST_IDLE: begin
        if (effValid) begin
          if (effData == CMD_LOAD) begin
            state_d   = ST_GET_LEN;
            loadErr_d = 1'b0;
            cpuHold_d = 1'b1;
          end else if (effData == CMD_RUN) begin
            cpuHold_d = 1'b0;
          end else if (effData == CMD_HALT) begin
            cpuHold_d = 1'b1;
          end
        end
      end

      ST_GET_LEN: begin
        if (effValid) begin
          if (lenOk) begin
            wordCount_d = CW'(effData);
            wordAddr_d  = '0;
            byteIdx_d   = 2'd0;
            state_d     = ST_GET_BYTE;
          end else begin
            loadErr_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end else if (tmoExpired) begin
          loadErr_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_GET_BYTE: begin
        if (effValid) begin
          assembly_d = {assembly_q[23:0], effData};
          byteIdx_d  = byteIdx_q + 2'd1;
          if (byteIdx_q == 2'd3) begin
            state_d = ST_WRITE;
          end
        end else if (tmoExpired) begin
          loadErr_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      // The final word leaves the address in place so it never wraps.
      ST_WRITE: begin
        holdValid_d = holdValid_q | rx_valid;
        if (rx_valid) hold_d = rx_data;
        dataInstr_d = assembly_q;
        if (lastWord) begin
          state_d = ST_DONE;
        end else begin
          wordAddr_d = wordAddr_q + AW'(1);
          state_d    = ST_GET_BYTE;
        end
      end

      ST_DONE: begin
        holdValid_d = holdValid_q | rx_valid;
        if (rx_valid) hold_d = rx_data;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wordCount_q <= '0;
      wordAddr_q  <= '0;
      byteIdx_q   <= 2'd0;
      assembly_q  <= 32'd0;
      dataInstr_q <= 32'd0;
      hold_q      <= 8'd0;
      holdValid_q <= 1'b0;
      cpuHold_q   <= 1'b1;
      loadErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wordCount_q <= wordCount_d;
      wordAddr_q  <= wordAddr_d;
      byteIdx_q   <= byteIdx_d;
      assembly_q  <= assembly_d;
      dataInstr_q <= dataInstr_d;
      hold_q      <= hold_d;
      holdValid_q <= holdValid_d;
      cpuHold_q   <= cpuHold_d;
      loadErr_q   <= loadErr_d;
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign wr_instruction   = (state_q == ST_WRITE);
  assign load_done        = (state_q == ST_DONE);
  assign data_instruction = wr_instruction ? assembly_q : dataInstr_q;
  assign imem_addr        = busy ? 32'(wordAddr_q) : pc_addr;
  assign cpu_hold         = cpuHold_q;
  assign load_err         = loadErr_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed sequences plus randomized
// loads and commands compared against a word-list / hold-flag reference model.
module tb_program_loader;

  localparam int MEM_DEPTH   = 32;
  localparam int TIMEOUT_CYC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] pc_addr;
  logic [31:0] imem_addr;
  logic        wr_instruction;
  logic [31:0] data_instruction;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;
  int doneCount  = 0;
  bit modelHold;

  logic [63:0] obsQ[$];
  logic [63:0] expQ[$];

  program_loader #(
    .MEM_DEPTH  (MEM_DEPTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .pc_addr         (pc_addr),
    .imem_addr       (imem_addr),
    .wr_instruction  (wr_instruction),
    .data_instruction(data_instruction),
    .cpu_hold        (cpu_hold),
    .load_done       (load_done),
    .load_err        (load_err),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Record every memory write and completion pulse seen on the interface.
  always @(negedge clk) begin
    if (wr_instruction) obsQ.push_back({imem_addr, data_instruction});
    if (load_done) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic compareWrites(input string tag);
    int n;
    checkOutput({tag, "_wrcount"}, 64'(obsQ.size()), 64'(expQ.size()));
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_wr%0d", tag, i), obsQ[i], expQ[i]);
    end
    obsQ.delete();
    expQ.delete();
  endtask

  // Builds 4*n data bytes, derives the expected word list, drives the load.
  task automatic runLoad(input string tag, input int n, input bit allowFast);
    logic [7:0] data[$];
    logic [7:0] b;
    int gap;
    int doneBefore;
    for (int i = 0; i < 4 * n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       b = 8'h4C;
          1:       b = 8'h52;
          default: b = 8'h48;
        endcase
      end else begin
        b = 8'($urandom_range(0, 255));
      end
      data.push_back(b);
    end
    for (int w = 0; w < n; w++) begin
      expQ.push_back({32'(w), data[4*w], data[4*w+1], data[4*w+2], data[4*w+3]});
    end
    doneBefore = doneCount;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'(n), $urandom_range(1, 3));
    for (int i = 0; i < 4 * n; i++) begin
      gap = $urandom_range(1, 3);
      if (allowFast && (i % 4 == 3) && (i != 4 * n - 1) && ($urandom_range(0, 1) == 1)) gap = 0;
      if (i == 4 * n - 1) gap = 1;
      applyStimulus(data[i], gap);
    end
    waitIdle(tag);
    compareWrites(tag);
    checkOutput({tag, "_done"}, 64'(doneCount - doneBefore), 64'd1);
    checkOutput({tag, "_err"}, 64'(load_err), 64'd0);
    modelHold = 1'b1;
    checkOutput({tag, "_hold"}, 64'(cpu_hold), 64'(modelHold));
  endtask

  initial begin
    int doneBefore;
    logic [7:0] cmd;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc_addr  = $urandom;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    modelHold = 1'b1;

    checkOutput("rst_hold", 64'(cpu_hold), 64'd1);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_wr", 64'(wr_instruction), 64'd0);
    checkOutput("rst_done", 64'(load_done), 64'd0);
    checkOutput("rst_err", 64'(load_err), 64'd0);
    checkOutput("rst_data", 64'(data_instruction), 64'd0);
    checkOutput("rst_addr", 64'(imem_addr), 64'(pc_addr));

    // Two-word load, then RUN arriving during the DONE cycle.
    doneBefore = doneCount;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h00, 1); applyStimulus(8'h22, 1);
    applyStimulus(8'h18, 1); applyStimulus(8'h20, 1);
    applyStimulus(8'h8C, 1); applyStimulus(8'h22, 1);
    applyStimulus(8'h00, 1); applyStimulus(8'h04, 1);
    checkOutput("seq_hold_done", 64'(cpu_hold), 64'd1);
    applyStimulus(8'h52, 1);
    waitIdle("seq");
    expQ.push_back({32'd0, 32'h0022_1820});
    expQ.push_back({32'd1, 32'h8C22_0004});
    compareWrites("seq");
    checkOutput("seq_done", 64'(doneCount - doneBefore), 64'd1);
    checkOutput("seq_run", 64'(cpu_hold), 64'd0);
    modelHold = 1'b0;
    pc_addr = $urandom;
    #1;
    checkOutput("seq_pcmux", 64'(imem_addr), 64'(pc_addr));

    // RUN byte as data must not release the CPU.
    applyStimulus(8'h4C, 1);
    checkOutput("cmd_hold_set", 64'(cpu_hold), 64'd1);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h52, 1);
    checkOutput("data52_hold", 64'(cpu_hold), 64'd1);
    applyStimulus(8'h13, 1); applyStimulus(8'h57, 1); applyStimulus(8'h52, 1);
    waitIdle("data52");
    expQ.push_back({32'd0, 32'h5213_5752});
    compareWrites("data52");
    modelHold = 1'b1;

    // Byte arriving in the WRITE cycle goes through the holding register.
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'h11, 1); applyStimulus(8'h22, 1);
    applyStimulus(8'h33, 1); applyStimulus(8'h44, 0);
    applyStimulus(8'h55, 1); applyStimulus(8'h66, 1);
    applyStimulus(8'h77, 1); applyStimulus(8'h88, 1);
    waitIdle("fast");
    expQ.push_back({32'd0, 32'h1122_3344});
    expQ.push_back({32'd1, 32'h5566_7788});
    compareWrites("fast");

    // Zero length, then LOAD clears the error, then GET_LEN times out.
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h00, 1);
    checkOutput("len0_err", 64'(load_err), 64'd1);
    checkOutput("len0_busy", 64'(busy), 64'd0);
    compareWrites("len0");
    applyStimulus(8'h4C, 1);
    checkOutput("len0_clear", 64'(load_err), 64'd0);
    checkOutput("len0_busy2", 64'(busy), 64'd1);
    idleCycles(TIMEOUT_CYC + 5);
    checkOutput("lentmo_err", 64'(load_err), 64'd1);
    checkOutput("lentmo_busy", 64'(busy), 64'd0);

    // Length one past the memory depth.
    applyStimulus(8'h4C, 1);
    applyStimulus(8'(MEM_DEPTH + 1), 1);
    checkOutput("lenbig_err", 64'(load_err), 64'd1);
    checkOutput("lenbig_busy", 64'(busy), 64'd0);
    checkOutput("lenbig_hold", 64'(cpu_hold), 64'd1);
    compareWrites("lenbig");

    // Full-depth load.
    runLoad("full", MEM_DEPTH, 1'b1);

    // Stall inside a word: timeout with no writes.
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h01, 1);
    applyStimulus(8'hAA, 1);
    applyStimulus(8'hBB, 0);
    idleCycles(TIMEOUT_CYC - 5);
    checkOutput("tmo_early_busy", 64'(busy), 64'd1);
    checkOutput("tmo_early_err", 64'(load_err), 64'd0);
    idleCycles(10);
    checkOutput("tmo_err", 64'(load_err), 64'd1);
    checkOutput("tmo_busy", 64'(busy), 64'd0);
    compareWrites("tmo");

    // Reset in the middle of a word.
    doneBefore = doneCount;
    applyStimulus(8'h4C, 1);
    applyStimulus(8'h02, 1);
    applyStimulus(8'hDE, 1);
    applyStimulus(8'hAD, 1);
    applyStimulus(8'hBE, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_wr", 64'(wr_instruction), 64'd0);
    checkOutput("midrst_err", 64'(load_err), 64'd0);
    checkOutput("midrst_hold", 64'(cpu_hold), 64'd1);
    checkOutput("midrst_data", 64'(data_instruction), 64'd0);
    checkOutput("midrst_addr", 64'(imem_addr), 64'(pc_addr));
    idleCycles(3);
    compareWrites("midrst");
    checkOutput("midrst_nodone", 64'(doneCount - doneBefore), 64'd0);
    modelHold = 1'b1;

    // Random command traffic interleaved with random loads.
    for (int it = 0; it < 6; it++) begin
      for (int c = 0; c < $urandom_range(1, 3); c++) begin
        case ($urandom_range(0, 2))
          0: begin cmd = 8'h52; modelHold = 1'b0; end
          1: begin cmd = 8'h48; modelHold = 1'b1; end
          default: begin
            do cmd = 8'($urandom_range(0, 255));
            while (cmd == 8'h4C || cmd == 8'h52 || cmd == 8'h48);
          end
        endcase
        applyStimulus(cmd, $urandom_range(1, 3));
        checkOutput($sformatf("rnd%0d_cmd%0d", it, c), 64'(cpu_hold), 64'(modelHold));
      end
      pc_addr = $urandom;
      #1;
      checkOutput($sformatf("rnd%0d_pcmux", it), 64'(imem_addr), 64'(pc_addr));
      runLoad($sformatf("rnd%0d", it), $urandom_range(1, 4), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
